// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage RV32I core.
// Tracks a shadow copy of the EX/MEM/WB destination state, detects
// load-use hazards, turns taken branches into IF/ID flushes and
// produces registered forwarding selects for the instruction entering EX.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   id_valid_i          ID stage holds a real instruction
//   id_opcode_i         7-bit opcode of the ID instruction
//   id_rs1_i/rs2_i/rd_i register IDs of the ID instruction
//   ex_branch_taken_i   branch/jump in EX resolved taken this cycle
//   stall_o             hold PC and IF/ID this cycle
//   flush_ifid_o        bubble into IF/ID at the next edge
//   bubble_idex_o       bubble into ID/EX at the next edge
//   fwd_a_sel_o/b_sel_o operand source for the EX instruction
//                       (00 regfile, 01 MEM result, 10 WB result)
//   stall_cnt_o         saturating count of stall cycles
//   flush_cnt_o         saturating count of flush cycles
module hazard_ctrl #(
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [6:0]        id_opcode_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic              ex_branch_taken_i,
  output logic              stall_o,
  output logic              flush_ifid_o,
  output logic              bubble_idex_o,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic [AWIDTH-1:0] stall_cnt_o,
  output logic [AWIDTH-1:0] flush_cnt_o
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_R     = 7'b0110011;

  localparam logic [AWIDTH-1:0] CNT_MAX = {AWIDTH{1'b1}};
  localparam logic [AWIDTH-1:0] CNT_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       writes_rd;
    logic       is_load;
  } stage_t;

  // Forwarding priority: the younger producer (shadow EX, about to be MEM)
  // wins over the older one (shadow MEM, about to be WB).
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                         input stage_t ex, input stage_t mem);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && ex.valid && ex.writes_rd && (ex.rd == src)) begin
      sel = 2'b01;
    end else if (used && mem.valid && mem.writes_rd && (mem.rd == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  stage_t ex_st, mem_st, wb_st;
  stage_t id_dec;
  logic   uses_rs1, uses_rs2, writes_rd, is_load, known;
  logic   load_use;
  logic   wb_unused;

  // WB is tracked so the shadow pipe matches the real one; same-cycle WB
  // reads are bypassed inside the register file, so nothing here uses it.
  assign wb_unused = ^wb_st;

  // Decode the ID instruction into source/destination usage flags.
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    known     = 1'b1;
    case (id_opcode_i)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        writes_rd = 1'b1;
      end
      OP_JALR, OP_I: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_B, OP_S: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_LOAD: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        is_load   = 1'b1;
      end
      OP_R: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      default: begin
        known = 1'b0;
      end
    endcase
    // Invalid slots and unknown opcodes behave as bubbles; x0 is never a producer.
    if (!id_valid_i || !known) begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      is_load   = 1'b0;
    end else if (id_rd_i == 5'd0) begin
      writes_rd = 1'b0;
    end else begin
      writes_rd = writes_rd;
    end
    id_dec = '{valid: id_valid_i & known, rd: id_rd_i, writes_rd: writes_rd, is_load: is_load};
  end

  // Hazard detection; a taken branch overrides a load-use stall.
  always_comb begin
    load_use = ex_st.valid && ex_st.is_load && ex_st.writes_rd &&
               ((uses_rs1 && (id_rs1_i == ex_st.rd)) || (uses_rs2 && (id_rs2_i == ex_st.rd)));
    if (ex_branch_taken_i) begin
      stall_o       = 1'b0;
      flush_ifid_o  = 1'b1;
      bubble_idex_o = 1'b1;
    end else begin
      stall_o       = load_use;
      flush_ifid_o  = 1'b0;
      bubble_idex_o = load_use;
    end
  end

  // Shadow pipeline, registered forward selects and event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_st       <= '0;
      mem_st      <= '0;
      wb_st       <= '0;
      fwd_a_sel_o <= 2'b00;
      fwd_b_sel_o <= 2'b00;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      wb_st  <= mem_st;
      mem_st <= ex_st;
      if (bubble_idex_o) begin
        ex_st       <= '0;
        fwd_a_sel_o <= 2'b00;
        fwd_b_sel_o <= 2'b00;
      end else begin
        ex_st       <= id_dec;
        fwd_a_sel_o <= fwd_sel(uses_rs1, id_rs1_i, ex_st, mem_st);
        fwd_b_sel_o <= fwd_sel(uses_rs2, id_rs2_i, ex_st, mem_st);
      end
      if (stall_o && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + CNT_ONE;
      end else begin
        stall_cnt_o <= stall_cnt_o;
      end
      if (flush_ifid_o && (flush_cnt_o != CNT_MAX)) begin
        flush_cnt_o <= flush_cnt_o + CNT_ONE;
      end else begin
        flush_cnt_o <= flush_cnt_o;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven testbench for hazard_ctrl.
// Counters are built 3 bits wide so saturation is reachable in a few cycles.
module tb_hazard_ctrl;

  localparam int AW = 3;

  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] OPR  = 7'b0110011;
  localparam logic [6:0] UNK  = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [6:0]    id_opcode;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          br;
  logic          stall, flush, bubble;
  logic [1:0]    fa, fb;
  logic [AW-1:0] scnt, fcnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.AWIDTH(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid_i        (id_valid),
    .id_opcode_i       (id_opcode),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_rd_i           (id_rd),
    .ex_branch_taken_i (br),
    .stall_o           (stall),
    .flush_ifid_o      (flush),
    .bubble_idex_o     (bubble),
    .fwd_a_sel_o       (fa),
    .fwd_b_sel_o       (fb),
    .stall_cnt_o       (scnt),
    .flush_cnt_o       (fcnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       br;
    logic       st;
    logic       fl;
    logic       bb;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [2:0] sc;
    logic [2:0] fc;
  } vec_t;

  vec_t tbl [34];

  function automatic vec_t mk(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic b,
                              input logic st, input logic fl, input logic bb,
                              input logic [1:0] xa, input logic [1:0] xb,
                              input logic [2:0] sc, input logic [2:0] fc);
    vec_t r;
    r = '{v: v, op: op, rs1: rs1, rs2: rs2, rd: rd, br: b, st: st, fl: fl, bb: bb,
          fa: xa, fb: xb, sc: sc, fc: fc};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic b);
    id_valid  = v;
    id_opcode = op;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
    br        = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             v  op   rs1 rs2 rd br  st fl bb fa fb sc fc
    tbl[0]  = mk(0, OPI, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 0); // first cycle after reset
    tbl[1]  = mk(1, OPI, 0,  0,  3,  0,  0, 0, 0, 0, 0, 0, 0); // ADDI x3,x0,1
    tbl[2]  = mk(1, OPR, 3,  3,  4,  0,  0, 0, 0, 0, 0, 0, 0); // ADD x4,x3,x3 no stall
    tbl[3]  = mk(0, OPI, 0,  0,  0,  0,  0, 0, 0, 1, 1, 0, 0); // ADD in EX: 01/01
    tbl[4]  = mk(1, OPI, 0,  0,  3,  0,  0, 0, 0, 0, 0, 0, 0); // ADDI x3
    tbl[5]  = mk(1, OPI, 0,  0,  3,  0,  0, 0, 0, 0, 0, 0, 0); // ADDI x3 again
    tbl[6]  = mk(1, OPR, 3,  0,  4,  0,  0, 0, 0, 0, 0, 0, 0); // ADD x4,x3,x0
    tbl[7]  = mk(0, OPI, 0,  0,  0,  0,  0, 0, 0, 1, 0, 0, 0); // younger wins, x0 no fwd
    tbl[8]  = mk(1, OPI, 0,  0,  5,  0,  0, 0, 0, 0, 0, 0, 0); // ADDI x5
    tbl[9]  = mk(1, OPI, 0,  0,  9,  0,  0, 0, 0, 0, 0, 0, 0); // ADDI x9
    tbl[10] = mk(1, OPR, 5,  9, 10,  0,  0, 0, 0, 0, 0, 0, 0); // ADD x10,x5,x9
    tbl[11] = mk(0, OPI, 0,  0,  0,  0,  0, 0, 0, 2, 1, 0, 0); // x5 from WB, x9 from MEM
    tbl[12] = mk(1, LD,  1,  0,  5,  0,  0, 0, 0, 0, 0, 0, 0); // LW x5
    tbl[13] = mk(1, OPR, 5,  7,  6,  0,  1, 0, 1, 0, 0, 0, 0); // ADD x6,x5,x7 stalls
    tbl[14] = mk(1, OPR, 5,  7,  6,  0,  0, 0, 0, 0, 0, 1, 0); // held, no second stall
    tbl[15] = mk(0, OPI, 0,  0,  0,  0,  0, 0, 0, 2, 0, 1, 0); // fwd_a = 10
    tbl[16] = mk(1, LD,  1,  0,  5,  0,  0, 0, 0, 0, 0, 1, 0); // LW x5
    tbl[17] = mk(1, OPR, 5,  7,  6,  1,  0, 1, 1, 0, 0, 1, 0); // load-use + branch
    tbl[18] = mk(0, OPI, 0,  0,  0,  0,  0, 0, 0, 0, 0, 1, 1); // flush counted only
    tbl[19] = mk(1, LD,  2,  0,  8,  0,  0, 0, 0, 0, 0, 1, 1); // LW x8
    tbl[20] = mk(1, ST,  3,  8, 11,  0,  1, 0, 1, 0, 0, 1, 1); // SW rs2=x8 stalls
    tbl[21] = mk(1, ST,  3,  8, 11,  0,  0, 0, 0, 0, 0, 2, 1); // held
    tbl[22] = mk(0, OPI, 0,  0,  0,  0,  0, 0, 0, 0, 2, 2, 1); // fwd_b = 10
    tbl[23] = mk(1, LD,  1,  0,  0,  0,  0, 0, 0, 0, 0, 2, 1); // LW x0
    tbl[24] = mk(1, ST,  1,  0, 11,  0,  0, 0, 0, 0, 0, 2, 1); // SW rs2=x0, no stall
    tbl[25] = mk(1, OPR, 11, 11, 12, 0,  0, 0, 0, 0, 0, 2, 1); // reads S rd bits
    tbl[26] = mk(0, OPI, 0,  0,  0,  0,  0, 0, 0, 0, 0, 2, 1); // no forwarding from S
    tbl[27] = mk(1, OPI, 0,  0, 15,  1,  0, 1, 1, 0, 0, 2, 1); // plain taken branch
    tbl[28] = mk(1, LD,  1,  0, 13,  0,  0, 0, 0, 0, 0, 2, 2); // LW x13
    tbl[29] = mk(1, UNK, 13, 13, 13, 0,  0, 0, 0, 0, 0, 2, 2); // unknown opcode: bubble
    tbl[30] = mk(1, LD,  1,  0, 13,  0,  0, 0, 0, 0, 0, 2, 2); // LW x13
    tbl[31] = mk(1, LUI, 13, 13, 14, 0,  0, 0, 0, 0, 0, 2, 2); // LUI uses no sources
    tbl[32] = mk(1, LD,  1,  0, 13,  0,  0, 0, 0, 0, 0, 2, 2); // LW x13
    tbl[33] = mk(0, OPR, 13, 13, 6,  0,  0, 0, 0, 0, 0, 2, 2); // invalid ID: no stall

    // Reset state, including branch passthrough while in reset.
    rst = 1'b1;
    drive(1'b0, OPI, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst flush", 32'(flush), 32'd0);
    chk("rst bubble", 32'(bubble), 32'd0);
    chk("rst fwd_a", 32'(fa), 32'd0);
    chk("rst fwd_b", 32'(fb), 32'd0);
    chk("rst scnt", 32'(scnt), 32'd0);
    chk("rst fcnt", 32'(fcnt), 32'd0);
    br = 1'b1;
    #1;
    chk("rst br flush", 32'(flush), 32'd1);
    chk("rst br bubble", 32'(bubble), 32'd1);
    chk("rst br stall", 32'(stall), 32'd0);
    tick();
    chk("rst br fcnt", 32'(fcnt), 32'd0);
    rst = 1'b0;
    br  = 1'b0;

    // Table of directed vectors.
    for (int i = 0; i < 34; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].br);
      @(negedge clk);
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(tbl[i].st));
      chk($sformatf("v%0d flush", i), 32'(flush), 32'(tbl[i].fl));
      chk($sformatf("v%0d bubble", i), 32'(bubble), 32'(tbl[i].bb));
      chk($sformatf("v%0d fwd_a", i), 32'(fa), 32'(tbl[i].fa));
      chk($sformatf("v%0d fwd_b", i), 32'(fb), 32'(tbl[i].fb));
      chk($sformatf("v%0d scnt", i), 32'(scnt), 32'(tbl[i].sc));
      chk($sformatf("v%0d fcnt", i), 32'(fcnt), 32'(tbl[i].fc));
      tick();
    end

    // Asynchronous reset in the middle of a stall cycle.
    drive(1'b1, LD, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    drive(1'b1, OPR, 5'd5, 5'd7, 5'd6, 1'b0);
    #2;
    chk("mid stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst stall", 32'(stall), 32'd0);
    chk("arst flush", 32'(flush), 32'd0);
    chk("arst bubble", 32'(bubble), 32'd0);
    chk("arst fwd_a", 32'(fa), 32'd0);
    chk("arst fwd_b", 32'(fb), 32'd0);
    chk("arst scnt", 32'(scnt), 32'd0);
    chk("arst fcnt", 32'(fcnt), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post rst stall", 32'(stall), 32'd0);
    chk("post rst bubble", 32'(bubble), 32'd0);
    tick();

    // Flush counter saturation.
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, OPI, 5'd0, 5'd0, 5'd0, 1'b1);
      tick();
    end
    chk("fcnt at max", 32'(fcnt), 32'd7);
    chk("scnt untouched", 32'(scnt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, OPI, 5'd0, 5'd0, 5'd0, 1'b1);
      tick();
    end
    chk("fcnt saturated", 32'(fcnt), 32'd7);

    // Stall counter saturation: LW x5 then a dependent ADD, repeated.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, LD, 5'd1, 5'd0, 5'd5, 1'b0);
      tick();
      drive(1'b1, OPR, 5'd5, 5'd7, 5'd6, 1'b0);
      tick();
      if (i == 6) begin
        chk("scnt at max", 32'(scnt), 32'd7);
      end
    end
    chk("scnt saturated", 32'(scnt), 32'd7);
    chk("fcnt held", 32'(fcnt), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: AWIDTH, 32, width of the stall and flush event counters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 id_valid_i  input  1  the ID stage holds a real instruction.
REQ-005 id_opcode_i  input  7  opcode of the ID-stage instruction, from decode.
REQ-006 id_rs1_i, id_rs2_i, id_rd_i  input  5 each  register IDs of the ID-stage instruction, from decode.
REQ-007 ex_branch_taken_i  input  1  the branch or jump in EX has resolved as taken this cycle.
REQ-008 stall_o  output  1  hold the PC and the IF/ID register this cycle.
REQ-009 flush_ifid_o  output  1  load a bubble into the IF/ID register at the next edge.
REQ-010 bubble_idex_o  output  1  load a bubble into the ID/EX register at the next edge.
REQ-011 fwd_a_sel_o, fwd_b_sel_o  output  2 each  operand source for the instruction in EX: 00 regfile, 01 MEM result, 10 WB result; registered.
REQ-012 stall_cnt_o, flush_cnt_o  output  AWIDTH each  saturating event counters.

Function
REQ-013 Opcode classes are the RV32I values: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, B 1100011, LOAD 0000011, S 0100011, I 0010011, R 0110011.
REQ-014 uses_rs1 is true for every class except LUI, AUIPC and JAL; uses_rs2 is true only for the R, S and B classes.
REQ-015 writes_rd is true for every class except S and B, and is forced false when rd == 0.
REQ-016 An unknown opcode, or id_valid_i = 0, is treated as a bubble: no sources are used and rd is not written.
REQ-017 Three shadow stages (EX, MEM, WB) each hold {valid, rd, writes_rd, is_load}; each stage is cleared by reset.
REQ-018 Each edge: WB <= MEM and MEM <= EX.
REQ-019 Each edge, EX <= the decoded ID instruction, unless bubble_idex_o = 1; in that case EX <= invalid.
REQ-020 load_use = EX.valid & EX.is_load & EX.writes_rd & ((uses_rs1 & rs1 == EX.rd) | (uses_rs2 & rs2 == EX.rd)); this signal is combinational.
REQ-021 Taken branch (ex_branch_taken_i = 1): flush_ifid_o = 1, bubble_idex_o = 1 and stall_o = 0, regardless of load_use; the flush wins.
REQ-022 Load-use stall (load_use = 1 without a taken branch): stall_o = 1, bubble_idex_o = 1 and flush_ifid_o = 0, for exactly one cycle; the ID instruction stays in place.
REQ-023 The second cycle of a stall re-evaluates load_use against the new EX content, which is a bubble, so it does not stall again.
REQ-024 Forward select for source s, computed from the ID instruction and registered at the edge:
  - 01 if EX.valid & EX.writes_rd & EX.rd == s;
  - otherwise 10 if MEM.valid & MEM.writes_rd & MEM.rd == s;
  - otherwise 00.
  - The MEM-stage producer (shadow EX, which becomes MEM) has priority over the WB-stage producer (shadow MEM).
REQ-025 The select for an unused source is 00.
REQ-026 The registered select is 00 whenever bubble_idex_o = 1.
REQ-027 Reads of a register being written in WB in the same cycle are bypassed by the register file, not by this block.
REQ-028 stall_cnt_o increments on each cycle with stall_o = 1; flush_cnt_o increments on each cycle with flush_ifid_o = 1.
REQ-029 Both counters hold at all-ones once saturated.
REQ-030 stall_o, flush_ifid_o and bubble_idex_o are combinational from the inputs and the shadow state; they contain no combinational path from the fwd outputs.

Reset
REQ-031 While rst = 1:
  - all shadow stages are invalid;
  - fwd_a_sel_o = fwd_b_sel_o = 00;
  - stall_cnt_o = flush_cnt_o = 0;
  - stall_o = flush_ifid_o = bubble_idex_o = 0, unless ex_branch_taken_i = 1.
REQ-032 Reset asserted in the middle of a stall clears the shadow stages immediately.
REQ-033 The first cycle after reset release shows no hazard.

Verification
REQ-034 LOAD x5 in ID, then ADD x6,x5,x7 in ID next cycle -> stall_o = 1 for one cycle, bubble_idex_o = 1, stall_cnt_o = 1; the next cycle after that gives fwd_a_sel_o = 10.
REQ-035 ADDI x3,x0,1 then ADD x4,x3,x3 back-to-back -> no stall; fwd_a_sel_o = fwd_b_sel_o = 01 while the ADD is in EX.
REQ-036 ADDI x3 writes, ADDI x3 writes, ADD x4,x3,x0 -> fwd_a_sel_o = 01 (younger producer wins); fwd_b_sel_o = 00 (x0 never forwards).
REQ-037 Load-use condition and ex_branch_taken_i = 1 in the same cycle -> flush_ifid_o = 1, bubble_idex_o = 1, stall_o = 0; flush_cnt_o increments and stall_cnt_o does not.
REQ-038 LOAD x0, then SW with rs2 = x0 -> no stall; S-type rd bits equal to a later rs -> no forwarding.
REQ-039 rst pulsed asynchronously during a stall cycle -> all outputs 0 before the next edge; counters preset to all-ones -> they remain all-ones after further events.
